// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key gesture decoder: FSM state encoding and tick-counter sizing.
package key_evt_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } key_state_e;

  // The counter must hold the largest threshold it is ever compared against.
  function automatic int cnt_width(input int long_ticks, input int dclk_ticks, input int repeat_ticks);
    int m;
    m = (long_ticks > dclk_ticks) ? long_ticks : dclk_ticks;
    m = (repeat_ticks > m) ? repeat_ticks : m;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Key gesture bus: the debounced key level toward the decoder and the event pulses back to UI logic.
interface key_event_decoder_if;

  logic KEY_In;
  logic KEY_Press;
  logic KEY_Rel;
  logic KEY_Click;
  logic KEY_DClick;
  logic KEY_Long;
  logic KEY_Repeat;

  modport master (
    output KEY_In,
    input  KEY_Press,
    input  KEY_Rel,
    input  KEY_Click,
    input  KEY_DClick,
    input  KEY_Long,
    input  KEY_Repeat
  );

  modport slave (
    input  KEY_In,
    output KEY_Press,
    output KEY_Rel,
    output KEY_Click,
    output KEY_DClick,
    output KEY_Long,
    output KEY_Repeat
  );

endinterface

// File: rtl/key_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, shared by timing blocks.
module key_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_q;
  logic             tick_d;

  // Next prescaler value; the tick is raised on the wrap back to zero.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      tick_d = 1'b1;
    end else begin
      div_d  = div_q + DIV_W'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced active-low key gestures into one-cycle press/release/click/double-click/long pulses.
// Auto-repeat while long-held is compiled in only when KEY_REPEAT_EN is defined.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 800,
  parameter int DCLK_TICKS   = 250,
  parameter int REPEAT_TICKS = 100
) (
  input logic                CLK,
  input logic                RST,
  key_event_decoder_if.slave bus
);

  localparam int CNT_W = cnt_width(LONG_TICKS, DCLK_TICKS, REPEAT_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] DCLK_TH = CNT_W'(DCLK_TICKS);

  logic             tick_s;
  logic             fall_s;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             long_hit_s;
  logic             dclk_hit_s;
  logic             cnt_clr_s;

  logic             key_q;
  logic             key_d;
  key_state_e       state_q;
  key_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;
  logic             rel_q;
  logic             rel_d;
  logic             click_q;
  logic             click_d;
  logic             dclick_q;
  logic             dclick_d;
  logic             long_q;
  logic             long_d;
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TH = CNT_W'(REPEAT_TICKS);
  logic             rep_hit_s;
  logic             rep_q;
  logic             rep_d;
`endif

  key_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick_s)
  );

  // Edges compare the previous sample against the live level so pulses land one cycle after the change.
  assign key_d      = bus.KEY_In;
  assign fall_s     = key_q & ~bus.KEY_In;
  assign rise_s     = ~key_q & bus.KEY_In;
  assign cnt_inc_s  = (tick_s && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_W'(1)) : cnt_q;
  assign long_hit_s = tick_s && (cnt_inc_s == LONG_TH);
  assign dclk_hit_s = tick_s && (cnt_inc_s == DCLK_TH);
`ifdef KEY_REPEAT_EN
  assign rep_hit_s  = tick_s && (cnt_inc_s == REP_TH);
`endif

  // Gesture FSM: an edge always takes priority over a threshold hit in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_clr_s = 1'b0;
    press_d   = fall_s;
    rel_d     = rise_s;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall_s) state_d = PRESS1;
        else        state_d = IDLE;
      end
      PRESS1: begin
        if (rise_s) begin
          state_d = WAIT2;
        end else if (long_hit_s) begin
          long_d  = 1'b1;
          state_d = LONG;
        end else begin
          state_d = PRESS1;
        end
      end
      WAIT2: begin
        if (fall_s) begin
          state_d = PRESS2;
        end else if (dclk_hit_s) begin
          click_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT2;
        end
      end
      PRESS2: begin
        if (rise_s) begin
          dclick_d = 1'b1;
          state_d  = IDLE;
        end else if (long_hit_s) begin
          dclick_d = 1'b1;
          state_d  = LONG;
        end else begin
          state_d  = PRESS2;
        end
      end
      LONG: begin
        if (rise_s) begin
          state_d = IDLE;
`ifdef KEY_REPEAT_EN
        end else if (rep_hit_s) begin
          rep_d     = 1'b1;
          cnt_clr_s = 1'b1;
          state_d   = LONG;
`endif
        end else begin
          state_d = LONG;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cnt_d = ((state_d != state_q) || cnt_clr_s) ? '0 : cnt_inc_s;
  end

  // Key sample, FSM state, tick counter and registered event pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      key_q    <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      key_q    <= key_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Repeat pulse register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rep_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign bus.KEY_Repeat = rep_q;
`else
  assign bus.KEY_Repeat = 1'b0;
`endif

  assign bus.KEY_Press  = press_q;
  assign bus.KEY_Rel    = rel_q;
  assign bus.KEY_Click  = click_q;
  assign bus.KEY_DClick = dclick_q;
  assign bus.KEY_Long   = long_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: gesture table, hand-timed corner cases and random gestures,
// every cycle compared against a gesture-level reference model.
`timescale 1ns/1ps
module tb_key_event_decoder;

  localparam int TD = 4;
  localparam int LT = 10;
  localparam int DT = 5;
  localparam int RT = 3;
`ifdef KEY_REPEAT_EN
  localparam int REP_EN = 1;
`else
  localparam int REP_EN = 0;
`endif

  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dclick;
    logic lng;
    logic rep;
  } ev_t;

  typedef struct {
    int seg[4];
    int nseg;
    int press;
    int rel;
    int click;
    int dclick;
    int lng;
    int rep;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  key_event_decoder_if bus ();

  key_event_decoder #(
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .DCLK_TICKS   (DT),
    .REPEAT_TICKS (RT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   c_press, c_rel, c_click, c_dclick, c_lng, c_rep;
  int   m_edges, m_ticks, m_start, m_presses;
  bit   m_long, m_down, m_prev;
  ev_t  m_exp;
  vec_t vecs[6];

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_edges   = 0;
    m_ticks   = 0;
    m_start   = 0;
    m_presses = 0;
    m_long    = 1'b0;
    m_down    = 1'b0;
    m_prev    = 1'b1;
    m_exp     = '0;
  endtask

  task automatic new_gesture();
    m_presses = 0;
    m_long    = 1'b0;
    m_down    = 1'b0;
    m_start   = m_ticks;
  endtask

  // Gesture model: counts presses in the current gesture and elapsed ticks since the last phase change.
  task automatic model_edge(input logic k);
    bit tick;
    bit fall;
    bit rise;
    int el;
    m_exp   = '0;
    m_edges = m_edges + 1;
    tick    = (m_edges > 1) && (((m_edges - 1) % TD) == 0);
    if (tick) m_ticks = m_ticks + 1;
    fall   = m_prev && !k;
    rise   = !m_prev && k;
    m_prev = k;
    m_exp.press = fall;
    m_exp.rel   = rise;
    el = m_ticks - m_start;
    if (m_long) begin
      if (rise) new_gesture();
      else if ((REP_EN != 0) && tick && (el == RT)) begin
        m_exp.rep = 1'b1;
        m_start   = m_ticks;
      end
    end else if (m_presses == 0) begin
      if (fall) begin
        m_presses = 1;
        m_down    = 1'b1;
        m_start   = m_ticks;
      end
    end else if (m_down) begin
      if (rise) begin
        if (m_presses == 2) begin
          m_exp.dclick = 1'b1;
          new_gesture();
        end else begin
          m_down  = 1'b0;
          m_start = m_ticks;
        end
      end else if (tick && (el == LT)) begin
        if (m_presses == 2) m_exp.dclick = 1'b1;
        else                m_exp.lng    = 1'b1;
        m_long  = 1'b1;
        m_start = m_ticks;
      end
    end else begin
      if (fall) begin
        m_presses = 2;
        m_down    = 1'b1;
        m_start   = m_ticks;
      end else if (tick && (el == DT)) begin
        m_exp.click = 1'b1;
        new_gesture();
      end
    end
  endtask

  function automatic ev_t observe();
    return {bus.KEY_Press, bus.KEY_Rel, bus.KEY_Click, bus.KEY_DClick, bus.KEY_Long, bus.KEY_Repeat};
  endfunction

  task automatic clear_counts();
    c_press = 0; c_rel = 0; c_click = 0; c_dclick = 0; c_lng = 0; c_rep = 0;
  endtask

  task automatic step(input logic k);
    ev_t obs;
    bus.KEY_In = k;
    @(posedge CLK);
    model_edge(k);
    #1;
    obs = observe();
    check("cycle_events", int'(obs), int'(m_exp));
    c_press  += int'(obs.press);
    c_rel    += int'(obs.rel);
    c_click  += int'(obs.click);
    c_dclick += int'(obs.dclick);
    c_lng    += int'(obs.lng);
    c_rep    += int'(obs.rep);
  endtask

  task automatic hold(input logic k, input int ticks);
    repeat (ticks * TD) step(k);
  endtask

  task automatic do_reset();
    bus.KEY_In = 1'b1;
    #1;
    RST = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", int'(observe()), 0);
    RST = 1'b1;
  endtask

  task automatic run_vec(input int i);
    clear_counts();
    for (int s = 0; s < vecs[i].nseg; s++) hold((s % 2) == 1, vecs[i].seg[s]);
    check($sformatf("v%0d_press", i),  c_press,  vecs[i].press);
    check($sformatf("v%0d_rel", i),    c_rel,    vecs[i].rel);
    check($sformatf("v%0d_click", i),  c_click,  vecs[i].click);
    check($sformatf("v%0d_dclick", i), c_dclick, vecs[i].dclick);
    check($sformatf("v%0d_long", i),   c_lng,    vecs[i].lng);
    check($sformatf("v%0d_repeat", i), c_rep,    vecs[i].rep);
  endtask

  initial begin
    int  seen;
    bit  found;
    bit  nt;
    int  len;

    // Segment lengths in ticks, alternating pressed/released, starting pressed.
    vecs[0] = '{'{3, 6, 0, 0},   2, 1, 1, 1, 0, 0, 0};
    vecs[1] = '{'{2, 2, 2, 8},   4, 2, 2, 0, 1, 0, 0};
    vecs[2] = '{'{20, 8, 0, 0},  2, 1, 1, 0, 0, 1, 3 * REP_EN};
    vecs[3] = '{'{2, 2, 14, 8},  4, 2, 2, 0, 1, 0, REP_EN};
    vecs[4] = '{'{2, 7, 2, 8},   4, 2, 2, 2, 0, 0, 0};
    vecs[5] = '{'{1, 6, 0, 0},   2, 1, 1, 1, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset in the middle of a first press discards the gesture.
    clear_counts();
    hold(1'b0, 5);
    do_reset();
    clear_counts();
    hold(1'b1, 12);
    check("rst_mid_rel",    c_rel,    0);
    check("rst_mid_click",  c_click,  0);
    check("rst_mid_long",   c_lng,    0);
    check("rst_mid_dclick", c_dclick, 0);
    run_vec(0);

    // Second press lands on the very tick that would confirm a single click.
    clear_counts();
    hold(1'b0, 2);
    step(1'b1);
    seen  = 0;
    found = 1'b0;
    for (int i = 0; (i < 20 * TD) && !found; i++) begin
      nt = ((m_edges + 1) > 1) && ((m_edges % TD) == 0);
      if (nt && (seen == DT - 1)) begin
        step(1'b0);
        found = 1'b1;
      end else begin
        step(1'b1);
        if (nt) seen++;
      end
    end
    check("race_aligned", int'(found), 1);
    hold(1'b0, 2);
    hold(1'b1, 8);
    check("race_dclick", c_dclick, 1);
    check("race_click",  c_click,  0);

    // Random gestures against the reference model.
    for (int g = 0; g < 60; g++) begin
      len = int'($urandom_range(1, 70));
      repeat (len) step((g % 2) == 1);
    end
    hold(1'b1, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
